// File: rtl/nt_pkg.sv
// Shared types for the neighbor-table read side: the entry record, table
// sizing constants and the reader state encoding.
package nt_pkg;

  localparam int NT_ENTRIES    = 32;
  localparam int NT_IDX_WIDTH  = $clog2(NT_ENTRIES);
  localparam int NT_WORD_WIDTH = 16;

  typedef struct packed {
    logic [NT_WORD_WIDTH-1:0] nodeID;
    logic [NT_WORD_WIDTH-1:0] hops;
    logic [NT_WORD_WIDTH-1:0] QValue;
    logic [NT_WORD_WIDTH-1:0] energy;
    logic [NT_WORD_WIDTH-1:0] CHHops;
    logic                     valid;
  } nt_entry_t;

  typedef enum logic [1:0] {
    NT_IDLE,
    NT_SCAN,
    NT_DONE
  } nt_state_e;

  // A neighbor with a drained battery is never a usable next hop.
  function automatic logic nt_eligible(input nt_entry_t e);
    return e.valid && (e.energy != '0);
  endfunction

endpackage

// File: rtl/nt_entry_compare.sv
// Ranks a candidate neighbor against the incumbent: higher QValue wins,
// equal QValue falls back to fewer hops; a full tie keeps the incumbent.
module nt_entry_compare
  import nt_pkg::*;
#(
  parameter int WORD_WIDTH = NT_WORD_WIDTH
) (
  input  logic [WORD_WIDTH-1:0] cand_qvalue,
  input  logic [WORD_WIDTH-1:0] cand_hops,
  input  logic [WORD_WIDTH-1:0] inc_qvalue,
  input  logic [WORD_WIDTH-1:0] inc_hops,
  output logic                  cand_better
);

  always_comb begin
    cand_better = (cand_qvalue > inc_qvalue) ||
                  ((cand_qvalue == inc_qvalue) && (cand_hops < inc_hops));
  end

endmodule

// File: rtl/neighbor_table_reader.sv
// Walks every neighbor-table entry once per start request and reports the
// best eligible next hop plus the number of eligible neighbors.
module neighbor_table_reader
  import nt_pkg::*;
#(
  parameter int WORD_WIDTH  = NT_WORD_WIDTH,
  parameter int NUM_ENTRIES = NT_ENTRIES,
  parameter int IDX_WIDTH   = NT_IDX_WIDTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  abort,
  output logic [IDX_WIDTH-1:0]  rd_idx,
  input  logic                  rd_valid,
  input  logic [WORD_WIDTH-1:0] rd_nodeID,
  input  logic [WORD_WIDTH-1:0] rd_nodeHops,
  input  logic [WORD_WIDTH-1:0] rd_nodeQValue,
  input  logic [WORD_WIDTH-1:0] rd_nodeEnergy,
  input  logic [WORD_WIDTH-1:0] rd_nodeCHHops,
  output logic                  busy,
  output logic                  done,
  output logic                  best_found,
  output logic [IDX_WIDTH-1:0]  best_idx,
  output logic [WORD_WIDTH-1:0] best_nodeID,
  output logic [WORD_WIDTH-1:0] best_QValue,
  output logic [WORD_WIDTH-1:0] best_hops,
  output logic [WORD_WIDTH-1:0] best_CHHops,
  output logic [IDX_WIDTH:0]    valid_count
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_ENTRIES - 1);

  nt_state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0]    rd_idx_q, rd_idx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    best_found_q, best_found_d;
  logic [IDX_WIDTH-1:0]    best_idx_q, best_idx_d;
  logic [WORD_WIDTH-1:0]   best_id_q, best_id_d;
  logic [WORD_WIDTH-1:0]   best_qvalue_q, best_qvalue_d;
  logic [WORD_WIDTH-1:0]   best_hops_q, best_hops_d;
  logic [WORD_WIDTH-1:0]   best_chhops_q, best_chhops_d;
  logic [IDX_WIDTH:0]      valid_count_q, valid_count_d;

  nt_entry_t cand;
  logic      cand_better;

  always_comb begin
    cand = '{nodeID: rd_nodeID, hops: rd_nodeHops, QValue: rd_nodeQValue,
             energy: rd_nodeEnergy, CHHops: rd_nodeCHHops, valid: rd_valid};
  end

  nt_entry_compare #(.WORD_WIDTH(WORD_WIDTH)) u_compare (
    .cand_qvalue (cand.QValue),
    .cand_hops   (cand.hops),
    .inc_qvalue  (best_qvalue_q),
    .inc_hops    (best_hops_q),
    .cand_better (cand_better)
  );

  always_comb begin
    state_d       = state_q;
    rd_idx_d      = rd_idx_q;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    best_found_d  = best_found_q;
    best_idx_d    = best_idx_q;
    best_id_d     = best_id_q;
    best_qvalue_d = best_qvalue_q;
    best_hops_d   = best_hops_q;
    best_chhops_d = best_chhops_q;
    valid_count_d = valid_count_q;

    unique case (state_q)
      NT_IDLE: begin
        if (start) begin
          state_d       = NT_SCAN;
          busy_d        = 1'b1;
          rd_idx_d      = '0;
          valid_count_d = '0;
          best_found_d  = 1'b0;
          best_idx_d    = '0;
          best_id_d     = '0;
          best_qvalue_d = '0;
          best_hops_d   = '0;
          best_chhops_d = '0;
        end
      end
      NT_SCAN: begin
        // Abort wins over everything, so the entry read this cycle never counts.
        if (abort) begin
          state_d       = NT_IDLE;
          best_found_d  = 1'b0;
          valid_count_d = '0;
        end else begin
          if (nt_eligible(cand)) begin
            valid_count_d = valid_count_q + (IDX_WIDTH+1)'(1);
            if (!best_found_q || cand_better) begin
              best_found_d  = 1'b1;
              best_idx_d    = rd_idx_q;
              best_id_d     = cand.nodeID;
              best_qvalue_d = cand.QValue;
              best_hops_d   = cand.hops;
              best_chhops_d = cand.CHHops;
            end
          end
          if (rd_idx_q == LAST_IDX) begin
            state_d = NT_DONE;
            done_d  = 1'b1;
          end else begin
            rd_idx_d = rd_idx_q + IDX_WIDTH'(1);
            busy_d   = 1'b1;
          end
        end
      end
      NT_DONE: begin
        state_d = NT_IDLE;
      end
      default: begin
        state_d = NT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q       <= NT_IDLE;
      rd_idx_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      best_found_q  <= 1'b0;
      best_idx_q    <= '0;
      best_id_q     <= '0;
      best_qvalue_q <= '0;
      best_hops_q   <= '0;
      best_chhops_q <= '0;
      valid_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rd_idx_q      <= rd_idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      best_found_q  <= best_found_d;
      best_idx_q    <= best_idx_d;
      best_id_q     <= best_id_d;
      best_qvalue_q <= best_qvalue_d;
      best_hops_q   <= best_hops_d;
      best_chhops_q <= best_chhops_d;
      valid_count_q <= valid_count_d;
    end
  end

  assign rd_idx      = rd_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign best_found  = best_found_q;
  assign best_idx    = best_idx_q;
  assign best_nodeID = best_id_q;
  assign best_QValue = best_qvalue_q;
  assign best_hops   = best_hops_q;
  assign best_CHHops = best_chhops_q;
  assign valid_count = valid_count_q;

endmodule

// File: tb/tb_neighbor_table_reader.sv
// Directed bench for neighbor_table_reader: a table-level model predicts the
// scan outcome and timing, and literal checks pin each directed scenario.
module tb_neighbor_table_reader;

  localparam int N  = 32;
  localparam int W  = 16;
  localparam int IW = 5;

  logic          clk;
  logic          nrst;
  logic          start;
  logic          abort;
  logic [IW-1:0] rd_idx;
  logic          rd_valid;
  logic [W-1:0]  rd_nodeID, rd_nodeHops, rd_nodeQValue, rd_nodeEnergy, rd_nodeCHHops;
  logic          busy, done, best_found;
  logic [IW-1:0] best_idx;
  logic [W-1:0]  best_nodeID, best_QValue, best_hops, best_CHHops;
  logic [IW:0]   valid_count;

  // Neighbor table contents, read combinationally at rd_idx.
  logic          t_v    [N];
  logic [W-1:0]  t_id   [N];
  logic [W-1:0]  t_hops [N];
  logic [W-1:0]  t_q    [N];
  logic [W-1:0]  t_en   [N];
  logic [W-1:0]  t_ch   [N];

  assign rd_valid      = t_v[rd_idx];
  assign rd_nodeID     = t_id[rd_idx];
  assign rd_nodeHops   = t_hops[rd_idx];
  assign rd_nodeQValue = t_q[rd_idx];
  assign rd_nodeEnergy = t_en[rd_idx];
  assign rd_nodeCHHops = t_ch[rd_idx];

  neighbor_table_reader #(.WORD_WIDTH(W), .NUM_ENTRIES(N), .IDX_WIDTH(IW)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .start         (start),
    .abort         (abort),
    .rd_idx        (rd_idx),
    .rd_valid      (rd_valid),
    .rd_nodeID     (rd_nodeID),
    .rd_nodeHops   (rd_nodeHops),
    .rd_nodeQValue (rd_nodeQValue),
    .rd_nodeEnergy (rd_nodeEnergy),
    .rd_nodeCHHops (rd_nodeCHHops),
    .busy          (busy),
    .done          (done),
    .best_found    (best_found),
    .best_idx      (best_idx),
    .best_nodeID   (best_nodeID),
    .best_QValue   (best_QValue),
    .best_hops     (best_hops),
    .best_CHHops   (best_CHHops),
    .valid_count   (valid_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit           found;
    int           idx;
    logic [W-1:0] id;
    logic [W-1:0] q;
    logic [W-1:0] hops;
    logic [W-1:0] ch;
    int           cnt;
  } res_t;

  function automatic res_t res_zero();
    res_t r;
    r.found = 1'b0; r.idx = 0; r.id = '0; r.q = '0; r.hops = '0; r.ch = '0; r.cnt = 0;
    return r;
  endfunction

  // Whole-table answer: best eligible entry by (QValue desc, hops asc, index asc).
  function automatic res_t best_of_table();
    res_t r = res_zero();
    for (int i = 0; i < N; i++) begin
      if (t_v[i] && t_en[i] != 0) begin
        r.cnt++;
        if (!r.found || t_q[i] > r.q || (t_q[i] == r.q && t_hops[i] < r.hops)) begin
          r.found = 1'b1; r.idx = i; r.id = t_id[i]; r.q = t_q[i];
          r.hops = t_hops[i]; r.ch = t_ch[i];
        end
      end
    end
    return r;
  endfunction

  // Model timeline: phase 0 idle, 1..N scanning (rd_idx = phase-1), N+1 done cycle.
  int   m_phase;
  int   m_rd_idx;
  res_t m_res;
  bit   m_known;

  always @(posedge clk or posedge nrst) begin
    if (nrst) begin
      m_phase  <= 0;
      m_rd_idx <= 0;
      m_res    <= res_zero();
      m_known  <= 1'b1;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase  <= 1;
        m_rd_idx <= 0;
        m_res    <= res_zero();
        m_known  <= 1'b1;
      end
    end else if (m_phase <= N) begin
      if (abort) begin
        m_phase     <= 0;
        m_res.found <= 1'b0;
        m_res.cnt   <= 0;
        m_known     <= 1'b0;
      end else if (m_phase == N) begin
        m_phase <= N + 1;
        m_res   <= best_of_table();
      end else begin
        m_phase  <= m_phase + 1;
        m_rd_idx <= m_rd_idx + 1;
      end
    end else begin
      m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= N));
      checkOutput("done", 32'(done), 32'(m_phase == N + 1));
      checkOutput("rd_idx", 32'(rd_idx), 32'(m_rd_idx));
      if (!(m_phase >= 1 && m_phase <= N)) begin
        checkOutput("best_found", 32'(best_found), 32'(m_res.found));
        checkOutput("valid_count", 32'(valid_count), 32'(m_res.cnt));
        if (m_known) begin
          checkOutput("best_idx", 32'(best_idx), 32'(m_res.idx));
          checkOutput("best_nodeID", 32'(best_nodeID), 32'(m_res.id));
          checkOutput("best_QValue", 32'(best_QValue), 32'(m_res.q));
          checkOutput("best_hops", 32'(best_hops), 32'(m_res.hops));
          checkOutput("best_CHHops", 32'(best_CHHops), 32'(m_res.ch));
        end
      end
    end
  end

  task automatic clearTable();
    for (int i = 0; i < N; i++) begin
      t_v[i] = 1'b0; t_id[i] = 16'h1000 + 16'(i); t_hops[i] = 16'd1;
      t_q[i] = '0;   t_en[i] = '0;                t_ch[i] = 16'h0200 + 16'(i);
    end
  endtask

  task automatic setEntry(input int idx, input logic [W-1:0] hops, input logic [W-1:0] q,
                          input logic [W-1:0] en);
    t_v[idx] = 1'b1; t_hops[idx] = hops; t_q[idx] = q; t_en[idx] = en;
  endtask

  task automatic applyStimulus(input bit s, input bit a);
    @(posedge clk);
    #2;
    start = s;
    abort = a;
  endtask

  task automatic waitDone(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic runScan(input string tag);
    int cyc;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    waitDone(cyc);
    checkOutput({tag, "_done_latency"}, 32'(cyc), 32'd33);
  endtask

  task automatic countDone(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
  endtask

  int pulses;

  initial begin
    nrst  = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    clearTable();
    repeat (2) @(posedge clk);
    #2 chk_en = 1'b1;
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_rd_idx", 32'(rd_idx), 32'd0);
    checkOutput("rst_valid_count", 32'(valid_count), 32'd0);
    checkOutput("rst_best_idx", 32'(best_idx), 32'd0);
    @(posedge clk);
    #2 nrst = 1'b0;

    $display("[TB] empty table");
    runScan("empty");
    checkOutput("empty_found", 32'(best_found), 32'd0);
    checkOutput("empty_count", 32'(valid_count), 32'd0);

    $display("[TB] three valid entries");
    clearTable();
    setEntry(3, 16'd1, 16'h0040, 16'h0100);
    setEntry(9, 16'd1, 16'h0080, 16'h0100);
    setEntry(20, 16'd1, 16'h0060, 16'h0100);
    runScan("three");
    checkOutput("three_idx", 32'(best_idx), 32'd9);
    checkOutput("three_q", 32'(best_QValue), 32'h0080);
    checkOutput("three_id", 32'(best_nodeID), 32'h1009);
    checkOutput("three_count", 32'(valid_count), 32'd3);

    $display("[TB] QValue tie broken on hops");
    clearTable();
    setEntry(4, 16'd3, 16'h0080, 16'h0100);
    setEntry(7, 16'd2, 16'h0080, 16'h0100);
    runScan("hops");
    checkOutput("hops_idx", 32'(best_idx), 32'd7);
    checkOutput("hops_ch", 32'(best_CHHops), 32'h0207);

    $display("[TB] full tie keeps first seen");
    t_hops[4] = 16'd2;
    runScan("tie");
    checkOutput("tie_idx", 32'(best_idx), 32'd4);
    checkOutput("tie_hops", 32'(best_hops), 32'd2);

    $display("[TB] zero energy excluded");
    clearTable();
    setEntry(5, 16'd1, 16'hFFFF, 16'h0000);
    setEntry(6, 16'd1, 16'h0010, 16'h0001);
    runScan("energy");
    checkOutput("energy_idx", 32'(best_idx), 32'd6);
    checkOutput("energy_count", 32'(valid_count), 32'd1);

    $display("[TB] every entry eligible");
    clearTable();
    for (int i = 0; i < N; i++) setEntry(i, 16'd5, 16'h0020, 16'h0001);
    t_hops[12] = 16'd1;
    t_hops[30] = 16'd1;
    runScan("full");
    checkOutput("full_idx", 32'(best_idx), 32'd12);
    checkOutput("full_count", 32'(valid_count), 32'd32);

    $display("[TB] abort mid-scan");
    clearTable();
    setEntry(3, 16'd1, 16'h0040, 16'h0100);
    setEntry(9, 16'd1, 16'h0080, 16'h0100);
    setEntry(20, 16'd1, 16'h0060, 16'h0100);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (9) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    countDone(40, pulses);
    checkOutput("abort_no_done", 32'(pulses), 32'd0);
    checkOutput("abort_found", 32'(best_found), 32'd0);
    checkOutput("abort_count", 32'(valid_count), 32'd0);

    $display("[TB] start while busy ignored");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    countDone(60, pulses);
    checkOutput("busy_start_done_pulses", 32'(pulses), 32'd1);
    checkOutput("busy_start_idx", 32'(best_idx), 32'd9);
    checkOutput("busy_start_count", 32'(valid_count), 32'd3);

    $display("[TB] reset mid-scan");
    clearTable();
    setEntry(4, 16'd3, 16'h0080, 16'h0100);
    setEntry(7, 16'd2, 16'h0080, 16'h0100);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (14) applyStimulus(1'b0, 1'b0);
    @(posedge clk);
    #2 nrst = 1'b1;
    @(negedge clk);
    checkOutput("mrst_busy", 32'(busy), 32'd0);
    checkOutput("mrst_done", 32'(done), 32'd0);
    checkOutput("mrst_rd_idx", 32'(rd_idx), 32'd0);
    checkOutput("mrst_found", 32'(best_found), 32'd0);
    checkOutput("mrst_count", 32'(valid_count), 32'd0);
    checkOutput("mrst_q", 32'(best_QValue), 32'd0);
    @(posedge clk);
    #2 nrst = 1'b0;
    runScan("post_rst");
    checkOutput("post_rst_idx", 32'(best_idx), 32'd7);
    checkOutput("post_rst_count", 32'(valid_count), 32'd2);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
